// File: rtl/spram_arb_pkg.sv
// Shared types and width defaults for the two-client single-port RAM arbiter.
package spram_arb_pkg;

  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned DATA_WIDTH = 16;

  typedef logic client_id_t;

  typedef struct packed {
    logic       valid;
    client_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant logic and priority pointer.
// SPRAM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise client 0 always wins.
module rr_arbiter2
  import spram_arb_pkg::*;
(
  input  logic in_clock,
  input  logic in_reset,
  input  logic in_valid_0,
  input  logic in_valid_1,
  output logic out_grant_0,
  output logic out_grant_1,
  output logic out_grant_id
);

`ifdef SPRAM_ARB_ROUND_ROBIN_EN
  client_id_t prio_q;
  client_id_t prio_d;

  always_comb begin
    out_grant_0 = 1'b0;
    out_grant_1 = 1'b0;
    if (!in_reset) begin
      if (in_valid_0 && in_valid_1) begin
        out_grant_0 = (prio_q == 1'b0);
        out_grant_1 = (prio_q == 1'b1);
      end else begin
        out_grant_0 = in_valid_0;
        out_grant_1 = in_valid_1;
      end
    end
    // pointer moves to the loser of every grant
    prio_d = prio_q;
    if (out_grant_0)      prio_d = 1'b1;
    else if (out_grant_1) prio_d = 1'b0;
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) prio_q <= '0;
    else          prio_q <= prio_d;
  end
`else
  always_comb begin
    out_grant_0 = !in_reset && in_valid_0;
    out_grant_1 = !in_reset && in_valid_1 && !in_valid_0;
  end
`endif

  assign out_grant_id = out_grant_1;

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port RAM between two clients; read responses are tagged and
// routed back to the issuing client two cycles after grant. Macro: SPRAM_ARB_ROUND_ROBIN_EN.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = spram_arb_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = spram_arb_pkg::DATA_WIDTH
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic                  in_req_valid_0,
  input  logic                  in_req_valid_1,
  output logic                  out_req_ready_0,
  output logic                  out_req_ready_1,
  input  logic                  in_req_write_0,
  input  logic                  in_req_write_1,
  input  logic [ADDR_WIDTH-1:0] in_req_address_0,
  input  logic [ADDR_WIDTH-1:0] in_req_address_1,
  input  logic [DATA_WIDTH-1:0] in_req_data_0,
  input  logic [DATA_WIDTH-1:0] in_req_data_1,
  output logic                  out_rsp_valid_0,
  output logic                  out_rsp_valid_1,
  output logic [DATA_WIDTH-1:0] out_rsp_data_0,
  output logic [DATA_WIDTH-1:0] out_rsp_data_1,
  output logic                  out_ram_enable,
  output logic                  out_ram_write,
  output logic [ADDR_WIDTH-1:0] out_ram_address,
  output logic [DATA_WIDTH-1:0] out_ram_data,
  input  logic [DATA_WIDTH-1:0] in_ram_data
);

  logic       grant_0;
  logic       grant_1;
  client_id_t grant_id;

  rd_tag_t tag1_q, tag1_d;
  rd_tag_t tag2_q, tag2_d;
  logic [DATA_WIDTH-1:0] rsp_data_0_q, rsp_data_0_d;
  logic [DATA_WIDTH-1:0] rsp_data_1_q, rsp_data_1_d;

  rr_arbiter2 u_arb (
    .in_clock     (in_clock),
    .in_reset     (in_reset),
    .in_valid_0   (in_req_valid_0),
    .in_valid_1   (in_req_valid_1),
    .out_grant_0  (grant_0),
    .out_grant_1  (grant_1),
    .out_grant_id (grant_id)
  );

  always_comb begin
    out_req_ready_0 = grant_0;
    out_req_ready_1 = grant_1;
    out_ram_enable  = grant_0 || grant_1;
    out_ram_write   = 1'b0;
    out_ram_address = '0;
    out_ram_data    = '0;
    if (grant_0) begin
      out_ram_write   = in_req_write_0;
      out_ram_address = in_req_address_0;
      out_ram_data    = in_req_data_0;
    end else if (grant_1) begin
      out_ram_write   = in_req_write_1;
      out_ram_address = in_req_address_1;
      out_ram_data    = in_req_data_1;
    end
  end

  // stage1 tracks the RAM read in flight; stage2 marks the cycle its data is presented
  always_comb begin
    tag1_d.valid = out_ram_enable && !out_ram_write;
    tag1_d.id    = grant_id;
    tag2_d       = tag1_q;
    rsp_data_0_d = rsp_data_0_q;
    rsp_data_1_d = rsp_data_1_q;
    if (tag1_q.valid && (tag1_q.id == 1'b0)) rsp_data_0_d = in_ram_data;
    if (tag1_q.valid && (tag1_q.id == 1'b1)) rsp_data_1_d = in_ram_data;
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      tag1_q       <= '0;
      tag2_q       <= '0;
      rsp_data_0_q <= '0;
      rsp_data_1_q <= '0;
    end else begin
      tag1_q       <= tag1_d;
      tag2_q       <= tag2_d;
      rsp_data_0_q <= rsp_data_0_d;
      rsp_data_1_q <= rsp_data_1_d;
    end
  end

  assign out_rsp_valid_0 = tag2_q.valid && (tag2_q.id == 1'b0);
  assign out_rsp_valid_1 = tag2_q.valid && (tag2_q.id == 1'b1);
  assign out_rsp_data_0  = rsp_data_0_q;
  assign out_rsp_data_1  = rsp_data_1_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed plus random bench for spram_arbiter with a behavioural RAM and a
// per-client scoreboard of expected read responses.
module tb_spram_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst;
  logic          v0, v1, w0, w1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          rdy0, rdy1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;
  logic          ram_en, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .in_clock         (clk),
    .in_reset         (rst),
    .in_req_valid_0   (v0),
    .in_req_valid_1   (v1),
    .out_req_ready_0  (rdy0),
    .out_req_ready_1  (rdy1),
    .in_req_write_0   (w0),
    .in_req_write_1   (w1),
    .in_req_address_0 (a0),
    .in_req_address_1 (a1),
    .in_req_data_0    (d0),
    .in_req_data_1    (d1),
    .out_rsp_valid_0  (rv0),
    .out_rsp_valid_1  (rv1),
    .out_rsp_data_0   (rd0),
    .out_rsp_data_1   (rd1),
    .out_ram_enable   (ram_en),
    .out_ram_write    (ram_wr),
    .out_ram_address  (ram_addr),
    .out_ram_data     (ram_wdata),
    .in_ram_data      (ram_rdata)
  );

  // behavioural stand-in for the spram: registered read, write at the enable edge
  logic [DW-1:0] ram_mem [1024];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   due;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] model_mem [1024];
  logic [DW-1:0] last0, last1;
  int unsigned   cyc;
  bit            rsp_known;
  bit            g0, g1;
  int            checks;
  int            failures;
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
  logic          mprio;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic step(input bit r,
                      input bit iv0, input bit iw0, input logic [AW-1:0] ia0, input logic [DW-1:0] id0,
                      input bit iv1, input bit iw1, input logic [AW-1:0] ia1, input logic [DW-1:0] id1);
    bit            e0, e1, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    exp_t          en;
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    v0 = iv0; w0 = iw0; a0 = ia0; d0 = id0;
    v1 = iv1; w1 = iw1; a1 = ia1; d1 = id1;
    @(negedge clk);
    e0 = 1'b0;
    e1 = 1'b0;
    if (!r) begin
      if (iv0 && iv1) begin
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
        e0 = (mprio == 1'b0);
        e1 = (mprio == 1'b1);
`else
        e0 = 1'b1;
`endif
      end else begin
        e0 = iv0;
        e1 = iv1;
      end
    end
    ew = e0 ? iw0 : (e1 ? iw1 : 1'b0);
    ea = e0 ? ia0 : (e1 ? ia1 : '0);
    ed = e0 ? id0 : (e1 ? id1 : '0);
    chk("ready_0", 32'(rdy0), 32'(e0));
    chk("ready_1", 32'(rdy1), 32'(e1));
    chk("ram_enable", 32'(ram_en), 32'(e0 | e1));
    chk("ram_write", 32'(ram_wr), 32'(ew));
    chk("ram_address", 32'(ram_addr), 32'(ea));
    chk("ram_data", 32'(ram_wdata), 32'(ed));
    if (rsp_known) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
        chk("rsp_valid_0", 32'(rv0), 32'd1);
        chk("rsp_data_0", 32'(rd0), 32'(q0[0].data));
        last0 = q0[0].data;
        void'(q0.pop_front());
      end else begin
        chk("rsp_valid_0", 32'(rv0), 32'd0);
        chk("rsp_data_0_hold", 32'(rd0), 32'(last0));
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
        chk("rsp_valid_1", 32'(rv1), 32'd1);
        chk("rsp_data_1", 32'(rd1), 32'(q1[0].data));
        last1 = q1[0].data;
        void'(q1.pop_front());
      end else begin
        chk("rsp_valid_1", 32'(rv1), 32'd0);
        chk("rsp_data_1_hold", 32'(rd1), 32'(last1));
      end
    end
    if (e0 || e1) begin
      if (ew) begin
        model_mem[ea] = ed;
      end else begin
        en.data = model_mem[ea];
        en.due  = cyc + 2;
        if (e0) q0.push_back(en);
        else    q1.push_back(en);
      end
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
      mprio = e0 ? 1'b1 : 1'b0;
`endif
    end
    if (r) begin
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
      mprio = 1'b0;
`endif
      while (q0.size() > 0 && q0[q0.size()-1].due > cyc) void'(q0.pop_back());
      while (q1.size() > 0 && q1[q1.size()-1].due > cyc) void'(q1.pop_back());
      last0 = '0;
      last1 = '0;
      rsp_known = 1'b1;
    end
    g0 = e0;
    g1 = e1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  bit            p0, p1;
  bit            pw0, pw1;
  logic [AW-1:0] pa0, pa1;
  logic [DW-1:0] pd0, pd1;

  initial begin
    checks = 0; failures = 0; cyc = 0; rsp_known = 1'b0;
    last0 = '0; last1 = '0;
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
    mprio = 1'b0;
`endif
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i]   = '0;
      model_mem[i] = '0;
    end
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;

    // reset held two cycles with both clients requesting
    step(1'b1, 1'b1, 1'b0, 10'd5, '0, 1'b1, 1'b0, 10'd6, '0);
    step(1'b1, 1'b1, 1'b0, 10'd5, '0, 1'b1, 1'b0, 10'd6, '0);

    // single client write then read back
    step(1'b0, 1'b1, 1'b1, 10'd10, 16'h1234, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, 10'd10, '0, 1'b0, 1'b0, '0, '0);
    idle(3);

    // contention from a freshly reset pointer
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 10'd20, '0, 1'b1, 1'b0, 10'd30, '0);
    idle(3);

    // read-after-write across clients
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'd20, 16'hABCD);
    step(1'b0, 1'b1, 1'b0, 10'd20, '0, 1'b0, 1'b0, '0, '0);
    idle(3);

    // reset while a read is in flight, then confirm pointer is back at 0
    step(1'b0, 1'b1, 1'b0, 10'd10, '0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 10'd30, '0, 1'b1, 1'b0, 10'd20, '0);
    idle(3);

    // random traffic; a request is held until it is granted
    p0 = 1'b0; p1 = 1'b0;
    pw0 = 1'b0; pw1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 300; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1; pw0 = 1'($urandom_range(0, 1));
        pa0 = AW'($urandom_range(0, 15)); pd0 = DW'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1; pw1 = 1'($urandom_range(0, 1));
        pa1 = AW'($urandom_range(0, 15)); pd1 = DW'($urandom);
      end
      step(1'b0, p0, pw0, pa0, pd0, p1, pw1, pa1, pd1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end
    idle(4);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
